// File: rtl/microcode_sequencer.sv
// Control unit for the 8-bit bus CPU: T0..T4 step counter, opcode decode,
// bus strobes and the registered zero/carry flags used by conditional jumps.
//
// step | meaning
// T0   | fetch: PC -> MAR
// T1   | fetch: RAM -> IR, PC++
// T2   | execute 1 (IR now holds the new opcode)
// T3   | execute 2
// T4   | execute 3 (ALU write-back, flag load)
module microcode_sequencer #(
  parameter int SKIP_IDLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zf_in,
  input  logic       cf_in,
  output logic       co,
  output logic       ce,
  output logic       j,
  output logic       mi,
  output logic       ro,
  output logic       ri,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       bi,
  output logic       eo,
  output logic       su,
  output logic       fi,
  output logic       oi,
  output logic       hlt,
  output logic [2:0] step,
  output logic       zf,
  output logic       cf,
  output logic       halted
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [15:0] C_CO  = 16'h8000;
  localparam logic [15:0] C_CE  = 16'h4000;
  localparam logic [15:0] C_J   = 16'h2000;
  localparam logic [15:0] C_MI  = 16'h1000;
  localparam logic [15:0] C_RO  = 16'h0800;
  localparam logic [15:0] C_RI  = 16'h0400;
  localparam logic [15:0] C_II  = 16'h0200;
  localparam logic [15:0] C_IO  = 16'h0100;
  localparam logic [15:0] C_AI  = 16'h0080;
  localparam logic [15:0] C_AO  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_EO  = 16'h0010;
  localparam logic [15:0] C_SU  = 16'h0008;
  localparam logic [15:0] C_FI  = 16'h0004;
  localparam logic [15:0] C_OI  = 16'h0002;
  localparam logic [15:0] C_HLT = 16'h0001;

  logic [15:0] ctl;
  logic [2:0]  last_step;
  logic        wrap;

  always_comb begin
    ctl = '0;
    if (!reset && !halted) begin
      case (step)
        T0: ctl = C_CO | C_MI;
        T1: ctl = C_RO | C_II | C_CE;
        default: begin
          case (opcode)
            4'h1: begin
              if (step == T2) ctl = C_IO | C_MI;
              else if (step == T3) ctl = C_RO | C_AI;
            end
            4'h2, 4'h3: begin
              if (step == T2) ctl = C_IO | C_MI;
              else if (step == T3) ctl = C_RO | C_BI;
              else if (step == T4)
                ctl = C_EO | C_AI | C_FI | ((opcode == 4'h3) ? C_SU : 16'h0000);
            end
            4'h4: begin
              if (step == T2) ctl = C_IO | C_MI;
              else if (step == T3) ctl = C_AO | C_RI;
            end
            4'h5: if (step == T2) ctl = C_IO | C_AI;
            4'h6: if (step == T2) ctl = C_IO | C_J;
            4'h7: if (step == T2 && cf) ctl = C_IO | C_J;
            4'h8: if (step == T2 && zf) ctl = C_IO | C_J;
            4'hE: if (step == T2) ctl = C_AO | C_OI;
            4'hF: if (step == T2) ctl = C_HLT;
            default: ctl = '0;
          endcase
        end
      endcase
    end
  end

  assign {co, ce, j, mi, ro, ri, ii, io, ai, ao, bi, eo, su, fi, oi, hlt} = ctl;

  always_comb begin
    case (opcode)
      4'h1, 4'h4:                         last_step = T3;
      4'h2, 4'h3:                         last_step = T4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: last_step = T2;
      default:                            last_step = T1;
    endcase
  end

  // >= rather than == so a step past the decoded end still returns to T0
  assign wrap = (step >= T4) || ((SKIP_IDLE != 0) && (step >= last_step));

  always_ff @(posedge clk) begin
    if (reset) begin
      step   <= T0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (fi) begin
        zf <= zf_in;
        cf <= cf_in;
      end
      if (hlt) halted <= 1'b1;
      else if (wrap) step <= T0;
      else step <= step + 3'd1;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed literal checks plus random stimulus
// against a per-cycle behavioural model, for both SKIP_IDLE settings.
module tb_microcode_sequencer;

  localparam logic [15:0] CO = 16'h8000, CE = 16'h4000, J = 16'h2000, MI = 16'h1000;
  localparam logic [15:0] RO = 16'h0800, RI = 16'h0400, II = 16'h0200, IO = 16'h0100;
  localparam logic [15:0] AI = 16'h0080, AO = 16'h0040, BI = 16'h0020, EO = 16'h0010;
  localparam logic [15:0] SU = 16'h0008, FI = 16'h0004, OI = 16'h0002, HLT = 16'h0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zf_in = 1'b0, cf_in = 1'b0;

  wire [15:0] st_a, st_b;
  wire [2:0]  step_a, step_b;
  wire        zf_a, cf_a, halted_a, zf_b, cf_b, halted_b;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  microcode_sequencer #(.SKIP_IDLE(0)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .zf_in(zf_in), .cf_in(cf_in),
    .co(st_a[15]), .ce(st_a[14]), .j(st_a[13]), .mi(st_a[12]), .ro(st_a[11]),
    .ri(st_a[10]), .ii(st_a[9]), .io(st_a[8]), .ai(st_a[7]), .ao(st_a[6]),
    .bi(st_a[5]), .eo(st_a[4]), .su(st_a[3]), .fi(st_a[2]), .oi(st_a[1]),
    .hlt(st_a[0]), .step(step_a), .zf(zf_a), .cf(cf_a), .halted(halted_a));

  microcode_sequencer #(.SKIP_IDLE(1)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .zf_in(zf_in), .cf_in(cf_in),
    .co(st_b[15]), .ce(st_b[14]), .j(st_b[13]), .mi(st_b[12]), .ro(st_b[11]),
    .ri(st_b[10]), .ii(st_b[9]), .io(st_b[8]), .ai(st_b[7]), .ao(st_b[6]),
    .bi(st_b[5]), .eo(st_b[4]), .su(st_b[3]), .fi(st_b[2]), .oi(st_b[1]),
    .hlt(st_b[0]), .step(step_b), .zf(zf_b), .cf(cf_b), .halted(halted_b));

  // ---------------- behavioural model ----------------
  int m_step [2];
  bit m_zf [2], m_cf [2], m_halt [2];

  function automatic int last_of(input logic [3:0] op);
    if (op == 4'h2 || op == 4'h3) return 4;
    if (op == 4'h1 || op == 4'h4) return 3;
    if (op inside {4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF}) return 2;
    return 1;
  endfunction

  function automatic logic [15:0] micro(input int s, input logic [3:0] op,
                                        input bit z, input bit c);
    if (s == 0) return CO | MI;
    if (s == 1) return RO | II | CE;
    case (op)
      4'h1: return (s == 2) ? (IO | MI) : (s == 3) ? (RO | AI) : 16'h0;
      4'h2: return (s == 2) ? (IO | MI) : (s == 3) ? (RO | BI) : (EO | AI | FI);
      4'h3: return (s == 2) ? (IO | MI) : (s == 3) ? (RO | BI) : (EO | AI | FI | SU);
      4'h4: return (s == 2) ? (IO | MI) : (s == 3) ? (AO | RI) : 16'h0;
      4'h5: return (s == 2) ? (IO | AI) : 16'h0;
      4'h6: return (s == 2) ? (IO | J) : 16'h0;
      4'h7: return (s == 2 && c) ? (IO | J) : 16'h0;
      4'h8: return (s == 2 && z) ? (IO | J) : 16'h0;
      4'hE: return (s == 2) ? (AO | OI) : 16'h0;
      4'hF: return (s == 2) ? HLT : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] model_out(input int k);
    if (reset || m_halt[k]) return 16'h0;
    return micro(m_step[k], opcode, m_zf[k], m_cf[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [15:0] s;
      s = model_out(k);
      if (reset) begin
        m_step[k] = 0; m_zf[k] = 0; m_cf[k] = 0; m_halt[k] = 0;
      end else if (!m_halt[k]) begin
        if ((s & FI) != 0) begin m_zf[k] = zf_in; m_cf[k] = cf_in; end
        if ((s & HLT) != 0) m_halt[k] = 1;
        else if (m_step[k] == 4 || (k == 1 && m_step[k] >= last_of(opcode))) m_step[k] = 0;
        else m_step[k] = m_step[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] gs, es;
        logic [5:0]  gst, est;
        gs  = (k == 0) ? st_a : st_b;
        gst = (k == 0) ? {step_a, zf_a, cf_a, halted_a} : {step_b, zf_b, cf_b, halted_b};
        es  = model_out(k);
        est = {3'(m_step[k]), m_zf[k], m_cf[k], m_halt[k]};
        n_vec++;
        if (gs !== es) begin
          n_mis++;
          $display("FAIL model_strobes[%0d] t=%0t got=%h exp=%h", k, $time, gs, es);
        end
        n_vec++;
        if (gst !== est) begin
          n_mis++;
          $display("FAIL model_state[%0d] t=%0t got{step,zf,cf,halted}=%b exp=%b", k, $time, gst, est);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [15:0] rec_st [5];
  logic [2:0]  rec_step [5];
  logic [1:0]  rec_fl [5];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic go(input logic r, input logic [3:0] op, input logic zi, input logic ci);
    @(posedge clk); #1;
    reset = r; opcode = op; zf_in = zi; cf_in = ci;
    #1;
  endtask

  task automatic run(input logic [3:0] op, input logic zi, input logic ci, input int n);
    for (int i = 0; i < n; i++) begin
      go(1'b0, op, zi, ci);
      rec_st[i] = st_b; rec_step[i] = step_b; rec_fl[i] = {zf_b, cf_b};
    end
  endtask

  initial begin
    go(1'b1, 4'h1, 1'b0, 1'b0);
    go(1'b1, 4'h1, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("reset_strobes", st_b, 16'h0);

    run(4'h1, 1'b1, 1'b1, 4);
    chk("lda_t0", rec_st[0], CO | MI);
    chk("lda_t1", rec_st[1], RO | II | CE);
    chk("lda_t2", rec_st[2], IO | MI);
    chk("lda_t3", rec_st[3], RO | AI);
    chk("lda_steps", {4'h0, rec_step[0], rec_step[1], rec_step[2], rec_step[3]}, 16'h0053);
    chk("reset_flags", {14'h0, rec_fl[3]}, 16'h0);

    run(4'h3, 1'b1, 1'b1, 5);
    chk("lda_wrap", {13'h0, rec_step[0]}, 16'h0);
    chk("sub_t4", rec_st[4], EO | AI | FI | SU);
    run(4'h5, 1'b0, 1'b0, 3);
    chk("sub_flags", {13'h0, rec_step[0], rec_fl[0]}, 16'h0003);
    chk("ldi_t2", rec_st[2], IO | AI);
    run(4'h2, 1'b0, 1'b0, 5);
    chk("ldi_keeps_flags", {13'h0, rec_step[0], rec_fl[0]}, 16'h0003);
    chk("add_t4", rec_st[4], EO | AI | FI);

    run(4'h7, 1'b1, 1'b1, 3);
    chk("jc_nojump", rec_st[2], 16'h0);
    run(4'h2, 1'b0, 1'b1, 5);
    chk("jc_return", {13'h0, rec_step[0], rec_fl[0]}, 16'h0);
    run(4'h7, 1'b0, 1'b0, 3);
    chk("jc_jump", rec_st[2], IO | J);
    run(4'h8, 1'b1, 1'b0, 3);
    chk("jz_nojump", rec_st[2], 16'h0);
    run(4'h2, 1'b1, 1'b0, 5);
    run(4'h8, 1'b0, 1'b1, 3);
    chk("jz_jump", rec_st[2], IO | J);
    chk("jz_flags", {14'h0, rec_fl[0]}, 16'h0002);

    run(4'hF, 1'b0, 1'b0, 3);
    chk("hlt_t2", rec_st[2], HLT);
    for (int i = 0; i < 20; i++) begin
      go(1'b0, 4'($urandom), 1'($urandom), 1'($urandom));
      chk("halt_strobes", st_b, 16'h0);
      chk("halt_state", {10'h0, step_b, zf_b, cf_b, halted_b}, 16'h0015);
    end
    go(1'b1, 4'h0, 1'b0, 1'b0);
    go(1'b0, 4'h0, 1'b0, 1'b0);
    chk("halt_cleared", {12'h0, step_b, halted_b}, 16'h0);

    run(4'h2, 1'b1, 1'b1, 5);
    run(4'h2, 1'b0, 1'b0, 3);
    go(1'b1, 4'h2, 1'b1, 1'b1);
    chk("reset_mid_strobes", st_b, 16'h0);
    go(1'b0, 4'h2, 1'b0, 1'b0);
    chk("reset_mid_state", {10'h0, step_b, zf_b, cf_b, halted_b}, 16'h0);
    chk("reset_mid_t0", st_b, CO | MI);

    go(1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      go(1'b0, 4'h0, 1'b1, 1'b1);
      chk("noidle_step", {13'h0, step_a}, 16'(i % 5));
      chk("noidle_strobes", st_a, (i % 5 == 0) ? (CO | MI) : (i % 5 == 1) ? (RO | II | CE) : 16'h0);
    end

    for (int i = 0; i < 800; i++)
      go(($urandom_range(0, 29) == 0), 4'($urandom), 1'($urandom), 1'($urandom));

    go(1'b0, 4'h0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Control unit for the 8-bit bus CPU.
- Runs a 5-step fetch/execute step counter, decodes the 4-bit opcode from the instruction register, and drives every bus enable/load strobe.
- Drives the ALU controls (eo, su) and holds the registered zero/carry flags latched from the ALU, which conditional jumps use.
- Sits between the instruction register/ALU flags and all datapath registers.

Parameters:
- SKIP_IDLE, 1: 1 = step counter returns to 0 after an instruction's last active step; 0 = always runs T0..T4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  instruction register upper nibble.
- zf_in  in  1  ALU zero flag.
- cf_in  in  1  ALU carry flag.
- co  out  1  PC onto bus.
- ce  out  1  PC increment.
- j  out  1  PC load from bus.
- mi  out  1  MAR load.
- ro  out  1  RAM onto bus.
- ri  out  1  RAM write.
- ii  out  1  IR load.
- io  out  1  IR operand onto bus.
- ai  out  1  A load.
- ao  out  1  A onto bus.
- bi  out  1  B load.
- eo  out  1  ALU result onto bus.
- su  out  1  ALU subtract select.
- fi  out  1  flag register load.
- oi  out  1  output register load.
- hlt  out  1  halt strobe.
- step  out  3  current microstep, 0..4.
- zf  out  1  registered zero flag.
- cf  out  1  registered carry flag.
- halted  out  1  sequencer stopped.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, sampled on the rising edge.
- Reset values: step=0, zf=0, cf=0, halted=0.
- Control outputs are combinational from (step, opcode, zf, cf, halted). They are forced to 0 while reset is high and while halted=1. The datapath samples them on the same rising edge that advances step.
- Reset mid-instruction aborts it; the first cycle after reset deasserts is T0.
- Fetch, identical for all opcodes:
  - T0: co, mi.
  - T1: ro, ii, ce.
- Execute by opcode. Unlisted steps assert nothing. Unlisted opcodes (9-D) behave as NOP.
  - 0 NOP: none.
  - 1 LDA: T2 io, mi; T3 ro, ai.
  - 2 ADD: T2 io, mi; T3 ro, bi; T4 eo, ai, fi.
  - 3 SUB: T2 io, mi; T3 ro, bi; T4 eo, ai, fi, su.
  - 4 STA: T2 io, mi; T3 ao, ri.
  - 5 LDI: T2 io, ai.
  - 6 JMP: T2 io, j.
  - 7 JC: T2 io, j only if cf=1. Otherwise T2 asserts nothing.
  - 8 JZ: T2 io, j only if zf=1. Otherwise T2 asserts nothing.
  - E OUT: T2 ao, oi.
  - F HLT: T2 hlt.
- Last active step:
  - NOP and 9-D: T1.
  - LDI, JMP, JC, JZ, OUT, HLT: T2.
  - LDA, STA: T3.
  - ADD, SUB: T4.
- Step counter:
  - SKIP_IDLE=1: step goes to 0 on the edge ending the last active step, otherwise increments.
  - SKIP_IDLE=0: step increments 0..4 and wraps 4->0.
  - Step never exceeds 4.
- Opcode sampling: opcode is sampled combinationally, so decode at T0/T1 is opcode-independent. IR is loaded at the end of T1, so T2+ sees the new opcode.
- Flags:
  - On an edge with fi=1: zf<=zf_in, cf<=cf_in. Otherwise flags hold.
  - JC/JZ use registered flags only, never zf_in/cf_in.
- Halt:
  - On the edge ending HLT T2: halted<=1, step holds at 2.
  - While halted: step, flags and halted frozen; all strobes 0.
  - Only reset clears halted.
- Simultaneous events: reset has priority over halt, flag load and step advance.

Test Plan:
- Reset, then opcode=1 (LDA) with SKIP_IDLE=1 -> step sequence 0,1,2,3,0. T0 {co,mi}, T1 {ro,ii,ce}, T2 {io,mi}, T3 {ro,ai}. No other strobe ever high.
- opcode=3 (SUB), zf_in=1, cf_in=1 at T4 -> T4 {eo,ai,fi,su}. Next cycle zf=1, cf=1, step=0. Flags unchanged by a following LDI (opcode=5).
- JC with cf=0 -> T2 asserts nothing, step returns to 0 after T2. After an ADD latching cf_in=1, JC -> T2 {io,j}. Repeat for JZ with zf.
- opcode=F -> hlt high for one cycle at T2, then halted=1, step=2, all strobes 0 for 20 cycles regardless of opcode/flag inputs. Reset -> halted=0, step=0.
- SKIP_IDLE=0, opcode=0 -> step 0,1,2,3,4,0 with no strobes at T2-T4.
- Reset asserted at T3 of ADD -> all strobes 0 that cycle. Next cycle step=0, zf=cf=0, T0 strobes {co,mi}.
